uart_frame_rx: RTL and testbench
================================

# uart_frame_rx

Serial-side receiver that decodes the asynchronous frames produced by `tx_engine` (start bit, 7 or 8 data bits LSB first, optional parity, one stop bit) and buffers each decoded character with its error flags in a 4-entry show-ahead FIFO. It sits on the far end of the `tx` line as the link partner/loopback checker for the UART. It uses the same `k` bit-time and `eight`/`pen`/`ohel` configuration inputs as the transmitter, and exposes a pop-on-`clr` read port modelled on the processor-side data/status ports.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two; only 4 is required to be verified.

Ports:
- `clk`, input, 1, system clock.
- `reset`, input, 1, asynchronous, active-high; clears all state.
- `rx`, input, 1, serial line; asynchronous to `clk`; idle high.
- `eight`, input, 1, 1 = 8 data bits, 0 = 7 data bits.
- `pen`, input, 1, parity bit present.
- `ohel`, input, 1, parity sense: 1 = odd, 0 = even.
- `k`, input, 19, clocks per bit time; legal range 4..333_333.
- `clr`, input, 1, single-cycle pulse that pops the head entry and clears `ovf`.
- `data`, output, 8, head entry character; `data[7]` is 0 in 7-bit mode; 0 when empty.
- `rxrdy`, output, 1, FIFO not empty.
- `ferr`, output, 1, head entry framing error (stop bit sampled 0); 0 when empty.
- `perr`, output, 1, head entry parity error; 0 when empty.
- `ovf`, output, 1, sticky: a frame was dropped because the FIFO was full.
- `busy`, output, 1, a frame is in progress (any state other than IDLE).
- `count`, output, 3, number of FIFO entries (0..4).

## Operation
- `rx` passes through a 2-flop synchronizer. All decoding uses the synchronized value `rxs`. A third flop holds `rxs_d` for edge detection.
- State machine states: IDLE, START, DATA, PARITY, STOP.
- IDLE: armed only after `rxs`=1 has been seen. A falling edge (`rxs_d`=1, `rxs`=0) latches `eight`, `pen`, `ohel`, and `k`, loads the bit timer with `k>>1`, and moves to START. Configuration changes mid-frame are ignored.
- The bit timer counts down. The sample point is the clock on which the timer reaches 0. It then reloads with the latched `k`-1, so each later sample falls at the middle of its bit.
- START sample: if `rxs`=1 (false start), go to IDLE with nothing pushed. If `rxs`=0, go to DATA.
- DATA: shift `rxs` in LSB first, for 8 bits (`eight`=1) or 7 bits (`eight`=0). Then go to PARITY if `pen`, otherwise STOP.
- PARITY: expected bit = XOR of received data bits, XOR `ohel`. A mismatch sets `perr` for the entry. With `pen`=0, `perr`=0.
- STOP sample: `ferr` = ~`rxs`. On this same clock edge, push {`ferr`, `perr`, `data`} and go to IDLE. If `ferr`=1, IDLE stays unarmed until `rxs`=1, so a break condition produces exactly one entry.
- Push when full: the entry is discarded, `ovf` is set, and FIFO contents are unchanged.
- `clr` pops the head entry when it is non-empty and always clears `ovf`. `clr` when empty has no effect other than clearing `ovf`.
- Push and `clr` on the same edge:
  - When full: pop and push both succeed, `count` stays 4, `ovf` is not set.
  - When empty: the pop is ignored and the push succeeds.
- If a push coincides with a `clr` that clears `ovf`, and the push overflows, `ovf` ends up 1.
- Read and write pointers wrap modulo `DEPTH`.

## Timing
- Reset values: `rxrdy`=0, `data`=0, `ferr`=0, `perr`=0, `ovf`=0, `busy`=0, `count`=0, state=IDLE (unarmed), synchronizer flops=1.
- Input latency: 2 clocks from an `rx` pin change to `rxs`. The falling edge is detected on the 3rd clock.
- Sample points (relative to the edge-detect clock):
  - START: `k>>1`+1 clocks after the edge detect.
  - Each subsequent bit: `k` clocks after the previous sample.
- `busy` rises on the clock after the edge detect. It falls on the clock after the STOP sample.
- Outputs go valid the cycle after the push edge: `rxrdy`, `count`, and the head `data`/`ferr`/`perr` all update on the clock after the STOP sample.
- Pop: after the `clr` edge, the next entry (or zeros) appears on the following cycle.
- Reset asserted mid-frame: the partial frame is discarded, FIFO is emptied, and the block waits for idle-high before re-arming.

## Test plan
- k=16, 8N1, send 0xA5 -> `rxrdy`=1, `data`=0xA5, `ferr`=0, `perr`=0, `count`=1. Then `clr` -> `rxrdy`=0, `data`=0.
- k=16, 7-bit, even parity (`pen`=1, `ohel`=0), send 0x55 with parity bit 0 -> `data`=0x55, `perr`=0. Repeat with parity bit 1 -> `perr`=1.
- k=16, 8N1, send 0x3C with stop bit 0, then hold `rx` low for 40 clocks -> exactly one entry: `data`=0x3C, `ferr`=1. Next frame 0x81 sent normally -> second entry 0x81, `ferr`=0.
- Glitch: `rx` low for 4 clocks with k=16 -> no entry, `busy` returns to 0, `count`=0.
- Send 5 frames 0x01..0x05 with no `clr` -> `count`=4, `ovf`=1, head `data`=0x01. Four `clr` pulses -> reads 0x01..0x04, `ovf`=0 after the first.
- FIFO full, with `clr` coinciding with the STOP sample of frame 0x66 -> `count`=4, `ovf`=0, tail entry 0x66. Separately: `reset` asserted mid-DATA -> all outputs return to reset values, and a subsequent clean frame 0x99 is received correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: asynchronous frame receiver for the tx_engine line format.
// Decoded characters and error flags are queued in a small show-ahead FIFO.
module uart_frame_rx #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        eight,
   input  logic        pen,
   input  logic        ohel,
   input  logic [18:0] k,
   input  logic        clr,
   output logic [7:0]  data,
   output logic        rxrdy,
   output logic        ferr,
   output logic        perr,
   output logic        ovf,
   output logic        busy,
   output logic [2:0]  count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state, state_n;

   logic        rx_m, rxs, rxs_d;
   logic        armed;
   logic        eight_q, pen_q, ohel_q;
   logic [18:0] k_q, timer;
   logic [7:0]  sr;
   logic [2:0]  bit_idx;
   logic        perr_q;
   logic        fire, tick, last_bit, push;

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [2:0]    cnt;
   logic          pop, wr;
   logic [9:0]    head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_m  <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         rx_m  <= rx;
         rxs   <= rx_m;
         rxs_d <= rxs;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      fire     = (state == IDLE) && armed && rxs_d && !rxs;
      tick     = (timer == 19'd0);
      last_bit = (bit_idx == (eight_q ? 3'd7 : 3'd6));
      state_n  = state;
      push     = 1'b0;
      unique case (state)
         IDLE:   if (fire) state_n = START;
         START:  if (tick) state_n = rxs ? IDLE : DATA;
         DATA:   if (tick && last_bit) state_n = pen_q ? PARITY : STOP;
         PARITY: if (tick) state_n = STOP;
         STOP: begin
            if (tick) begin
               state_n = IDLE;
               push    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // armed tracks the last sampled line level so a break only re-arms on high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed   <= 1'b0;
         eight_q <= 1'b0;
         pen_q   <= 1'b0;
         ohel_q  <= 1'b0;
         k_q     <= '0;
         timer   <= '0;
         sr      <= '0;
         bit_idx <= '0;
         perr_q  <= 1'b0;
      end else if (fire) begin
         armed   <= 1'b0;
         eight_q <= eight;
         pen_q   <= pen;
         ohel_q  <= ohel;
         k_q     <= k;
         timer   <= k >> 1;
         sr      <= '0;
         bit_idx <= '0;
         perr_q  <= 1'b0;
      end else if (state == IDLE) begin
         armed <= armed | rxs;
      end else if (tick) begin
         timer <= k_q - 19'd1;
         armed <= rxs;
         if (state == DATA) begin
            sr[bit_idx] <= rxs;
            bit_idx     <= bit_idx + 3'd1;
         end
         if (state == PARITY) perr_q <= (^sr ^ ohel_q) != rxs;
      end else begin
         timer <= timer - 19'd1;
      end
   end

   assign pop = clr && (cnt != 3'd0);
   assign wr  = push && ((cnt != 3'(DEPTH)) || pop);

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= {~rxs, perr_q, sr};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         if (wr)  wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + 3'(wr) - 3'(pop);
         if (push && !wr) ovf <= 1'b1;
         else if (clr)    ovf <= 1'b0;
      end
   end

   assign head  = mem[rp];
   assign rxrdy = (cnt != 3'd0);
   assign data  = rxrdy ? head[7:0] : 8'd0;
   assign perr  = rxrdy & head[8];
   assign ferr  = rxrdy & head[9];
   assign busy  = (state != IDLE);
   assign count = cnt;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: scenario tasks plus randomized frames checked
// against a line-level model of the frame format.
module tb_uart_frame_rx;

   logic        clk = 1'b0;
   logic        reset, rx, eight, pen, ohel, clr;
   logic [18:0] k;
   logic [7:0]  data;
   logic        rxrdy, ferr, perr, ovf, busy;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_frame_rx #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .eight(eight), .pen(pen), .ohel(ohel),
      .k(k), .clr(clr), .data(data),
      .rxrdy(rxrdy), .ferr(ferr), .perr(perr),
      .ovf(ovf), .busy(busy), .count(count)
   );

   // parity bit a correct transmitter appends
   function automatic logic par_bit(input logic [7:0] d,
                                    input logic e,
                                    input logic odd);
      logic [7:0] m;
      m = e ? d : (d & 8'h7F);
      return logic'($countones(m) % 2) ^ odd;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int kk);
      rx = b;
      repeat (kk) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic e,
                             input logic p, input logic pb,
                             input logic o, input logic stop,
                             input int kk);
      eight = e;
      pen   = p;
      ohel  = o;
      k     = 19'(kk);
      drive_bit(1'b0, kk);
      for (int i = 0; i < (e ? 8 : 7); i++) drive_bit(d[i], kk);
      if (p) drive_bit(pb, kk);
      drive_bit(stop, kk);
   endtask

   task automatic pop();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx = 1'b1;
      clr = 1'b0;
      eight = 1'b1;
      pen = 1'b0;
      ohel = 1'b0;
      k = 19'd16;
      idle(3);
      tests++;
      if ({rxrdy, data, ferr, perr, ovf, busy, count} !== 15'd0) begin
         fails++;
         $display("FAIL reset_outs: got %h want 0",
                  {rxrdy, data, ferr, perr, ovf, busy, count});
      end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_8n1();
      send_frame(8'hA5, 1, 0, 0, 0, 1, 16);
      idle(2);
      tests++;
      if (rxrdy !== 1'b1) begin
         fails++; $display("FAIL 8n1_rxrdy: got %b want 1", rxrdy);
      end
      tests++;
      if (data !== 8'hA5) begin
         fails++; $display("FAIL 8n1_data: got %h want a5", data);
      end
      tests++;
      if ({ferr, perr} !== 2'b00) begin
         fails++; $display("FAIL 8n1_err: got %b want 00", {ferr, perr});
      end
      tests++;
      if (count !== 3'd1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL 8n1_cnt: got %0d/%b want 1/0", count, busy);
      end
      pop();
      tests++;
      if (rxrdy !== 1'b0 || data !== 8'h00) begin
         fails++;
         $display("FAIL 8n1_pop: got %b/%h want 0/00", rxrdy, data);
      end
   endtask

   task automatic test_parity();
      for (int pb = 0; pb < 2; pb++) begin
         send_frame(8'h55, 0, 1, 1'(pb), 0, 1, 16);
         idle(2);
         tests++;
         if (data !== 8'h55 || perr !== 1'(pb) || ferr !== 1'b0) begin
            fails++;
            $display("FAIL par_%0d: got %h p%b f%b want 55 p%0d f0",
                     pb, data, perr, ferr, pb);
         end
         pop();
      end
   endtask

   task automatic test_break();
      send_frame(8'h3C, 1, 0, 0, 0, 0, 16);
      idle(40);
      rx = 1'b1;
      idle(20);
      tests++;
      if (count !== 3'd1) begin
         fails++; $display("FAIL brk_cnt: got %0d want 1", count);
      end
      tests++;
      if (data !== 8'h3C || ferr !== 1'b1) begin
         fails++;
         $display("FAIL brk_head: got %h f%b want 3c f1", data, ferr);
      end
      send_frame(8'h81, 1, 0, 0, 0, 1, 16);
      idle(2);
      tests++;
      if (count !== 3'd2) begin
         fails++; $display("FAIL brk_cnt2: got %0d want 2", count);
      end
      pop();
      tests++;
      if (data !== 8'h81 || ferr !== 1'b0) begin
         fails++;
         $display("FAIL brk_next: got %h f%b want 81 f0", data, ferr);
      end
      pop();
   endtask

   task automatic test_glitch();
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(3);
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL glitch_busy: got %b want 1", busy);
      end
      idle(20);
      tests++;
      if (busy !== 1'b0 || count !== 3'd0 || rxrdy !== 1'b0) begin
         fails++;
         $display("FAIL glitch_end: got b%b c%0d want b0 c0", busy, count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1, 0, 0, 0, 1, 16);
         idle(2);
      end
      tests++;
      if (count !== 3'd4 || ovf !== 1'b1 || data !== 8'h01) begin
         fails++;
         $display("FAIL ovf_full: got c%0d o%b %h want c4 o1 01",
                  count, ovf, data);
      end
      for (int i = 1; i <= 4; i++) begin
         tests++;
         if (data !== 8'(i)) begin
            fails++; $display("FAIL ovf_rd%0d: got %h want %h", i, data, 8'(i));
         end
         pop();
         tests++;
         if (ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_clr%0d: got %b want 0", i, ovf);
         end
      end
      tests++;
      if (count !== 3'd0) begin
         fails++; $display("FAIL ovf_empty: got %0d want 0", count);
      end
   endtask

   task automatic test_clr_on_full();
      int n;
      for (int i = 0; i < 4; i++) begin
         send_frame(8'h10 + 8'(i), 1, 0, 0, 0, 1, 16);
         idle(2);
      end
      // stop sample lands 4 + k/2 + 9k clocks after the first clock edge
      n = 3 + (16 >> 1) + 9 * 16;
      fork
         send_frame(8'h66, 1, 0, 0, 0, 1, 16);
         begin
            repeat (n) @(posedge clk);
            #1 clr = 1'b1;
            @(posedge clk);
            #1 clr = 1'b0;
         end
      join
      idle(2);
      tests++;
      if (count !== 3'd4 || ovf !== 1'b0) begin
         fails++;
         $display("FAIL cof_state: got c%0d o%b want c4 o0", count, ovf);
      end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp;
         exp = (i == 3) ? 8'h66 : 8'h11 + 8'(i);
         tests++;
         if (data !== exp) begin
            fails++; $display("FAIL cof_rd%0d: got %h want %h", i, data, exp);
         end
         pop();
      end
   endtask

   task automatic test_reset_mid();
      send_frame(8'h42, 1, 0, 0, 0, 1, 16);
      idle(2);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      drive_bit(1'b0, 16);
      drive_bit(1'b1, 16);
      tests++;
      if (busy !== 1'b1 || count !== 3'd1) begin
         fails++;
         $display("FAIL rmid_pre: got b%b c%0d want b1 c1", busy, count);
      end
      reset = 1'b1;
      #2;
      tests++;
      if ({rxrdy, data, ferr, perr, ovf, busy, count} !== 15'd0) begin
         fails++;
         $display("FAIL rmid_outs: got %h want 0",
                  {rxrdy, data, ferr, perr, ovf, busy, count});
      end
      idle(2);
      rx = 1'b1;
      reset = 1'b0;
      idle(5);
      send_frame(8'h99, 1, 0, 0, 0, 1, 16);
      idle(2);
      tests++;
      if (data !== 8'h99 || count !== 3'd1 || {ferr, perr} !== 2'b00) begin
         fails++;
         $display("FAIL rmid_99: got %h c%0d want 99 c1", data, count);
      end
      pop();
   endtask

   task automatic test_random();
      for (int t = 0; t < 16; t++) begin
         logic [7:0] d, exp_d;
         logic e, p, o, bad, pb, exp_p;
         int kk;
         d   = 8'($urandom);
         e   = 1'($urandom);
         p   = 1'($urandom);
         o   = 1'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         kk  = $urandom_range(12, 24);
         pb  = par_bit(d, e, o) ^ bad;
         exp_d = e ? d : (d & 8'h7F);
         exp_p = p & bad;
         send_frame(d, e, p, pb, o, 1, kk);
         idle(2);
         tests++;
         if (rxrdy !== 1'b1 || data !== exp_d ||
             perr !== exp_p || ferr !== 1'b0) begin
            fails++;
            $display("FAIL rnd%0d: got r%b %h p%b f%b want r1 %h p%b f0",
                     t, rxrdy, data, perr, ferr, exp_d, exp_p);
         end
         pop();
         tests++;
         if (count !== 3'd0) begin
            fails++; $display("FAIL rnd%0d_pop: got %0d want 0", t, count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_break();
      test_glitch();
      test_overflow();
      test_clr_on_full();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
